// File: rtl/rf_seq_ctrl.sv
// Multi-cycle main control unit: sequences fetch/decode/execute/memory/write-back
// and counts retired instructions. Optional memory-wait timeout: RF_SEQ_CTRL_TIMEOUT_EN.
module rf_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ir_op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             C_PCWrite,
    output logic             C_IRWrite,
    output logic             C_MemRead,
    output logic             C_MemWrite,
    output logic             C_IorD,
    output logic [1:0]       C_ALUSrcB,
    output logic [2:0]       C_ALUOp,
    output logic             C_RegDstWrite,
    output logic             C_RegWrite,
    output logic             C_MemToReg,
    output logic [3:0]       state,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_PC1 = 3'd4;

    state_t           state_q, state_d;
    // Low opcode bits latched in DECODE: [2] clear = R-type, [1:0] = ALU op / LW-vs-SW.
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;
    logic             retire;

`ifdef RF_SEQ_CTRL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              in_wait;
    logic              timeout;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RESET;
            op_q     <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

`ifdef RF_SEQ_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout = in_wait && !mem_ready && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        retire  = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = ir_op[2:0];
                case (ir_op)
                    4'b0000, 4'b0001,
                    4'b0010, 4'b0011: state_d = S_EXEC_R;
                    4'b0100:          state_d = S_EXEC_I;
                    4'b1000, 4'b1001: state_d = S_MEM_ADDR;
                    4'b1100:          state_d = S_BRANCH;
                    4'b1111: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = op_q[0] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
`ifdef RF_SEQ_CTRL_TIMEOUT_EN
        wait_d = '0;
        if (timeout) begin
            state_d = S_HALT;
            err_d   = 1'b1;
            retire  = 1'b0;
        end else if (in_wait && state_d == state_q) begin
            wait_d = wait_q + 1'b1;
        end
`endif
        halted_d = halted_q | (state_d == S_HALT);
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // Moore decode from state_q; FETCH (mem_ready) and BRANCH (zero) gate PCWrite/IRWrite.
    always_comb begin
        C_PCWrite     = 1'b0;
        C_IRWrite     = 1'b0;
        C_MemRead     = 1'b0;
        C_MemWrite    = 1'b0;
        C_IorD        = 1'b0;
        C_ALUSrcB     = 2'd0;
        C_ALUOp       = 3'd0;
        C_RegDstWrite = 1'b0;
        C_RegWrite    = 1'b0;
        C_MemToReg    = 1'b0;
        case (state_q)
            S_FETCH: begin
                C_MemRead = 1'b1;
                C_ALUSrcB = 2'd1;
                C_ALUOp   = ALU_PC1;
                C_IRWrite = mem_ready;
                C_PCWrite = mem_ready;
            end
            S_EXEC_R: C_ALUOp = {1'b0, op_q[1:0]};
            S_EXEC_I, S_MEM_ADDR: begin
                C_ALUSrcB = 2'd2;
                C_ALUOp   = ALU_ADD;
            end
            S_MEM_RD: begin
                C_IorD    = 1'b1;
                C_MemRead = 1'b1;
            end
            S_MEM_WR: begin
                C_IorD     = 1'b1;
                C_MemWrite = 1'b1;
            end
            S_WB_ALU: begin
                C_RegWrite    = 1'b1;
                C_RegDstWrite = ~op_q[2];
            end
            S_WB_MEM: begin
                C_RegWrite = 1'b1;
                C_MemToReg = 1'b1;
            end
            S_BRANCH: begin
                C_ALUOp   = ALU_SUB;
                C_PCWrite = zero;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign halted      = halted_q;
    assign err         = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Self-checking bench for rf_seq_ctrl: a cycle-by-cycle vector table for the main
// instruction flows plus hand-written sequences for halt, mid-instruction reset and waits.
module tb_rf_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ir_op;
    logic        zero;
    logic        mem_ready;
    logic        C_PCWrite, C_IRWrite, C_MemRead, C_MemWrite, C_IorD;
    logic [1:0]  C_ALUSrcB;
    logic [2:0]  C_ALUOp;
    logic        C_RegDstWrite, C_RegWrite, C_MemToReg;
    logic [3:0]  state;
    logic        halted, err;
    logic [15:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_seq_ctrl #(.TIMEOUT_CYCLES(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ir_op(ir_op), .zero(zero), .mem_ready(mem_ready),
        .C_PCWrite(C_PCWrite), .C_IRWrite(C_IRWrite), .C_MemRead(C_MemRead),
        .C_MemWrite(C_MemWrite), .C_IorD(C_IorD), .C_ALUSrcB(C_ALUSrcB),
        .C_ALUOp(C_ALUOp), .C_RegDstWrite(C_RegDstWrite), .C_RegWrite(C_RegWrite),
        .C_MemToReg(C_MemToReg), .state(state), .halted(halted), .err(err),
        .instr_count(instr_count)
    );

    logic [12:0] act_ctl;
    assign act_ctl = {C_PCWrite, C_IRWrite, C_MemRead, C_MemWrite, C_IorD,
                      C_ALUSrcB, C_ALUOp, C_RegDstWrite, C_RegWrite, C_MemToReg};

    function automatic logic [12:0] c(input logic pcw, input logic irw, input logic mr,
                                      input logic mw, input logic iord, input logic [1:0] srcb,
                                      input logic [2:0] aop, input logic rd, input logic rw,
                                      input logic m2r);
        return {pcw, irw, mr, mw, iord, srcb, aop, rd, rw, m2r};
    endfunction

    logic [12:0] C0, FR, FW, MA, MRD, MWR, WBR, WBI, WBM, BR0, BR1, EXR0, EXR3;

    typedef struct {
        logic [3:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [12:0] ctl;
        logic [15:0] cnt;
        logic        hlt;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] op, input logic z, input logic rdy, input logic [3:0] st,
                       input logic [12:0] ctl, input logic [15:0] cnt, input logic hlt,
                       input logic er);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
        v.hlt = hlt; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ir_op = 4'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset state", 32'(state), 32'd0);
        chk("reset ctl", 32'(act_ctl), 32'd0);
        chk("reset cnt/flags", {14'd0, halted, err, instr_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cyc(input logic [3:0] op, input logic z, input logic rdy);
        ir_op = op; zero = z; mem_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        C0   = '0;
        FR   = c(1, 1, 1, 0, 0, 2'd1, 3'd4, 0, 0, 0);
        FW   = c(0, 0, 1, 0, 0, 2'd1, 3'd4, 0, 0, 0);
        MA   = c(0, 0, 0, 0, 0, 2'd2, 3'd0, 0, 0, 0);
        MRD  = c(0, 0, 1, 0, 1, 2'd0, 3'd0, 0, 0, 0);
        MWR  = c(0, 0, 0, 1, 1, 2'd0, 3'd0, 0, 0, 0);
        WBR  = c(0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 1, 0);
        WBI  = c(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 1, 0);
        WBM  = c(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 1, 1);
        BR0  = c(0, 0, 0, 0, 0, 2'd0, 3'd1, 0, 0, 0);
        BR1  = c(1, 0, 0, 0, 0, 2'd0, 3'd1, 0, 0, 0);
        EXR0 = c(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0);
        EXR3 = c(0, 0, 0, 0, 0, 2'd0, 3'd3, 0, 0, 0);

        // op, zero, ready | state, controls, count, halted, err (current cycle)
        add(4'h0, 0, 1, 4'd0,  C0,   16'd0, 0, 0);  // RESET
        add(4'h0, 0, 1, 4'd1,  FR,   16'd0, 0, 0);  // ADD
        add(4'h0, 0, 1, 4'd2,  C0,   16'd0, 0, 0);
        add(4'h0, 0, 1, 4'd3,  EXR0, 16'd0, 0, 0);
        add(4'h0, 0, 1, 4'd8,  WBR,  16'd0, 0, 0);
        add(4'h8, 0, 0, 4'd1,  FW,   16'd1, 0, 0);  // LW, fetch waits once
        add(4'h8, 0, 1, 4'd1,  FR,   16'd1, 0, 0);
        add(4'h8, 0, 1, 4'd2,  C0,   16'd1, 0, 0);
        add(4'h8, 0, 1, 4'd5,  MA,   16'd1, 0, 0);
        add(4'h8, 0, 0, 4'd6,  MRD,  16'd1, 0, 0);
        add(4'h8, 0, 0, 4'd6,  MRD,  16'd1, 0, 0);
        add(4'h8, 0, 0, 4'd6,  MRD,  16'd1, 0, 0);
        add(4'h8, 0, 1, 4'd6,  MRD,  16'd1, 0, 0);
        add(4'h8, 0, 1, 4'd9,  WBM,  16'd1, 0, 0);
        add(4'hC, 0, 1, 4'd1,  FR,   16'd2, 0, 0);  // BEQ not taken
        add(4'hC, 0, 1, 4'd2,  C0,   16'd2, 0, 0);
        add(4'hC, 0, 1, 4'd10, BR0,  16'd2, 0, 0);
        add(4'hC, 1, 1, 4'd1,  FR,   16'd3, 0, 0);  // BEQ taken
        add(4'hC, 1, 1, 4'd2,  C0,   16'd3, 0, 0);
        add(4'hC, 1, 1, 4'd10, BR1,  16'd3, 0, 0);
        add(4'h4, 0, 1, 4'd1,  FR,   16'd4, 0, 0);  // ADDI
        add(4'h4, 0, 1, 4'd2,  C0,   16'd4, 0, 0);
        add(4'h4, 0, 1, 4'd4,  MA,   16'd4, 0, 0);
        add(4'h4, 0, 1, 4'd8,  WBI,  16'd4, 0, 0);
        add(4'h3, 0, 1, 4'd1,  FR,   16'd5, 0, 0);  // OR
        add(4'h3, 0, 1, 4'd2,  C0,   16'd5, 0, 0);
        add(4'h3, 0, 1, 4'd3,  EXR3, 16'd5, 0, 0);
        add(4'h3, 0, 1, 4'd8,  WBR,  16'd5, 0, 0);
        add(4'h9, 0, 1, 4'd1,  FR,   16'd6, 0, 0);  // SW
        add(4'h9, 0, 1, 4'd2,  C0,   16'd6, 0, 0);
        add(4'h9, 0, 1, 4'd5,  MA,   16'd6, 0, 0);
        add(4'h9, 0, 0, 4'd7,  MWR,  16'd6, 0, 0);
        add(4'h9, 0, 1, 4'd7,  MWR,  16'd6, 0, 0);
        add(4'hF, 0, 1, 4'd1,  FR,   16'd7, 0, 0);  // HLT
        add(4'hF, 0, 1, 4'd2,  C0,   16'd7, 0, 0);
        add(4'hF, 0, 1, 4'd11, C0,   16'd8, 1, 0);
        add(4'hF, 1, 0, 4'd11, C0,   16'd8, 1, 0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            ir_op = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d ctl", i), 32'(act_ctl), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d cnt/flags", i), {14'd0, halted, err, instr_count},
                {14'd0, vecs[i].hlt, vecs[i].er, vecs[i].cnt});
            @(posedge clk);
            #2;
        end

        // Illegal opcode: HALT with err, no retire, absorbing
        do_reset();
        cyc(4'h7, 0, 1);
        cyc(4'h7, 0, 1);
        cyc(4'h7, 0, 1);
        chk("illegal state", 32'(state), 32'd11);
        chk("illegal flags/cnt", {14'd0, halted, err, instr_count}, {14'd0, 1'b1, 1'b1, 16'd0});
        for (int i = 0; i < 20; i++) begin
            cyc(4'(i), i[0], i[1]);
            chk($sformatf("halt hold %0d", i), {16'(state), 16'(act_ctl)}, {16'd11, 16'd0});
        end

        // Reset in the middle of a load drops the read at once
        do_reset();
        cyc(4'h8, 0, 1);
        cyc(4'h8, 0, 1);
        cyc(4'h8, 0, 1);
        cyc(4'h8, 0, 0);
        chk("midrst pre state", 32'(state), 32'd6);
        chk("midrst pre ctl", 32'(act_ctl), 32'(MRD));
        rst = 1'b1;
        #1;
        chk("midrst state", 32'(state), 32'd0);
        chk("midrst ctl", 32'(act_ctl), 32'd0);

        // Store with memory never ready
        do_reset();
        cyc(4'h9, 0, 1);
        cyc(4'h9, 0, 1);
        cyc(4'h9, 0, 1);
        cyc(4'h9, 0, 0);
        chk("sw wait entry", 32'(state), 32'd7);
`ifdef RF_SEQ_CTRL_TIMEOUT_EN
        repeat (14) cyc(4'h9, 0, 0);
        chk("timeout 14 still waiting", 32'(state), 32'd7);
        cyc(4'h9, 0, 0);
        chk("timeout halt state", 32'(state), 32'd11);
        chk("timeout flags/cnt", {14'd0, halted, err, instr_count}, {14'd0, 1'b1, 1'b1, 16'd0});
`else
        repeat (100) cyc(4'h9, 0, 0);
        chk("no timeout state", 32'(state), 32'd7);
        chk("no timeout flags/cnt", {14'd0, halted, err, instr_count}, 32'd0);
        chk("no timeout ctl", 32'(act_ctl), 32'(MWR));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
